// File: rtl/taxi_axis_if.sv
// AXI-Stream bundle carrying tdata/tvalid/tready/tuser between a source and a sink.
interface taxi_axis_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned USER_W = 1
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic [USER_W-1:0] tuser;

   modport master (output tdata, output tvalid, output tuser, input tready);
   modport slave  (input tdata, input tvalid, input tuser, output tready);
endinterface

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 5-9 data bits, optional parity, 1/2 stop bits,
// break and idle-timeout detection, one-entry AXI-Stream output register.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit.
module uart_rx_ovs #(
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned MAX_DATA_W   = 9,
   parameter int unsigned TIMEOUT_BITS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             baud_clk,
   input  logic             rxd,
   taxi_axis_if.master      m_axis,
   input  logic [2:0]       data_bits,
   input  logic             stop_bits,
   input  logic             parity_en,
   input  logic             parity_type,
   output logic             busy,
   output logic             idle,
   output logic             overrun_error,
   output logic             frame_error,
   output logic             parity_error,
   output logic             break_det,
   output logic             rx_timeout
);
   localparam int unsigned TcW     = $clog2(OVERSAMPLE);
   localparam int unsigned ToLimit = TIMEOUT_BITS * OVERSAMPLE;
   localparam int unsigned ToW     = $clog2(ToLimit);
   localparam logic [TcW-1:0] Mid  = TcW'(OVERSAMPLE / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [TcW-1:0] MidM1 = TcW'(OVERSAMPLE / 2 - 2);
   localparam logic [TcW-1:0] Dec   = TcW'(OVERSAMPLE / 2);
`else
   localparam logic [TcW-1:0] Dec   = Mid;
`endif

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

   state_e                  state_q, state_d;
   logic [TcW-1:0]          tc_q, tc_d;
   logic [3:0]              bc_q, bc_d;
   logic                    sc_q, sc_d;
   logic [MAX_DATA_W-1:0]   data_q, data_d;
   logic                    par_q, par_d, zero_q, zero_d, ferr_q, ferr_d, perr_q, perr_d;
   logic [ToW-1:0]          to_q, to_d;
   logic                    armed_q, armed_d;
   logic                    tvalid_q, tvalid_d, tuser_q, tuser_d;
   logic [MAX_DATA_W-1:0]   tdata_q, tdata_d;
   logic                    ovr_q, ovr_d, ferr_p_q, ferr_p_d, perr_p_q, perr_p_d;
   logic                    brk_q, to_p_q;
   logic                    rxd_meta, rxs;
   logic                    bit_val, at_dec, complete, brk, to_pulse, ferr_fin;
   logic [3:0]              nbits, shamt;

   // Two-flop synchronizer; idles high out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxs      <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxs      <= rxd_meta;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] maj_q, maj_d;

   // Capture the two samples preceding the decision tick.
   always_comb begin
      maj_d = maj_q;
      if (baud_clk && tc_q == MidM1) maj_d[0] = rxs;
      if (baud_clk && tc_q == Mid)   maj_d[1] = rxs;
   end

   // Majority sample store.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) maj_q <= 2'b11;
      else     maj_q <= maj_d;
   end

   assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs) | (maj_q[1] & rxs);
`else
   assign bit_val = rxs;
`endif

   assign at_dec   = baud_clk && (tc_q == Dec);
   assign ferr_fin = ferr_q | ~bit_val;
   assign shamt    = 4'(MAX_DATA_W) - nbits;

   // Decode the data-bit count; 9 bits only when the bus is wide enough.
   always_comb begin
      case (data_bits)
         3'd1:    nbits = 4'd7;
         3'd2:    nbits = 4'd6;
         3'd3:    nbits = 4'd5;
         3'd4:    nbits = (MAX_DATA_W >= 9) ? 4'd9 : 4'd8;
         default: nbits = 4'd8;
      endcase
   end

   // Frame FSM next state and receive datapath.
   always_comb begin
      state_d  = state_q;
      tc_d     = tc_q;
      bc_d     = bc_q;
      sc_d     = sc_q;
      data_d   = data_q;
      par_d    = par_q;
      zero_d   = zero_q;
      ferr_d   = ferr_q;
      perr_d   = perr_q;
      complete = 1'b0;
      brk      = 1'b0;
      if (baud_clk) tc_d = tc_q + 1'b1;
      if (!en) begin
         state_d = StIdle;
         tc_d    = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (baud_clk && !rxs) begin
                  state_d = StStart;
                  tc_d    = '0;
               end
            end
            StStart: begin
               if (at_dec) begin
                  if (bit_val) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StData;
                     bc_d    = '0;
                     data_d  = '0;
                     par_d   = 1'b0;
                     zero_d  = 1'b1;
                     ferr_d  = 1'b0;
                     perr_d  = 1'b0;
                  end
               end
            end
            StData: begin
               if (at_dec) begin
                  data_d = {bit_val, data_q[MAX_DATA_W-1:1]};
                  par_d  = par_q ^ bit_val;
                  zero_d = zero_q & ~bit_val;
                  bc_d   = bc_q + 1'b1;
                  if (bc_q == nbits - 4'd1) begin
                     state_d = parity_en ? StParity : StStop;
                     sc_d    = 1'b0;
                  end
               end
            end
            StParity: begin
               if (at_dec) begin
                  if (bit_val != (par_q ^ parity_type)) perr_d = 1'b1;
                  zero_d  = zero_q & ~bit_val;
                  state_d = StStop;
                  sc_d    = 1'b0;
               end
            end
            StStop: begin
               if (at_dec) begin
                  if (!sc_q && zero_q && !bit_val) begin
                     brk     = 1'b1;
                     state_d = StBreak;
                  end else begin
                     ferr_d = ferr_fin;
                     if (sc_q == stop_bits) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                     end else begin
                        sc_d = 1'b1;
                     end
                  end
               end
            end
            StBreak: begin
               if (baud_clk && rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Idle timeout: armed by a completed frame, counts baud ticks while idle.
   always_comb begin
      to_d     = to_q;
      armed_d  = armed_q;
      to_pulse = 1'b0;
      if (!en) begin
         to_d    = '0;
         armed_d = 1'b0;
      end else if (complete) begin
         to_d    = '0;
         armed_d = 1'b1;
      end else if (state_q == StIdle && state_d != StIdle) begin
         to_d = '0;
      end else if (state_q == StIdle && armed_q && baud_clk) begin
         if (to_q == ToW'(ToLimit - 1)) begin
            to_pulse = 1'b1;
            armed_d  = 1'b0;
            to_d     = '0;
         end else begin
            to_d = to_q + 1'b1;
         end
      end
   end

   // Output register: load on free slot or same-cycle accept, else overrun.
   always_comb begin
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tuser_d  = tuser_q;
      ovr_d    = 1'b0;
      ferr_p_d = 1'b0;
      perr_p_d = 1'b0;
      if (complete) begin
         ferr_p_d = ferr_fin;
         perr_p_d = perr_q;
         if (!tvalid_q || m_axis.tready) begin
            tvalid_d = 1'b1;
            tdata_d  = data_q >> shamt;
            tuser_d  = ferr_fin | perr_q;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (tvalid_q && m_axis.tready) begin
         tvalid_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         tc_q     <= '0;
         bc_q     <= '0;
         sc_q     <= 1'b0;
         data_q   <= '0;
         par_q    <= 1'b0;
         zero_q   <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         to_q     <= '0;
         armed_q  <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
         tuser_q  <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_p_q <= 1'b0;
         perr_p_q <= 1'b0;
         brk_q    <= 1'b0;
         to_p_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tc_q     <= tc_d;
         bc_q     <= bc_d;
         sc_q     <= sc_d;
         data_q   <= data_d;
         par_q    <= par_d;
         zero_q   <= zero_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         to_q     <= to_d;
         armed_q  <= armed_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
         tuser_q  <= tuser_d;
         ovr_q    <= ovr_d;
         ferr_p_q <= ferr_p_d;
         perr_p_q <= perr_p_d;
         brk_q    <= brk;
         to_p_q   <= to_pulse;
      end
   end

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tuser  = {1'b0, tuser_q};
   assign busy          = (state_q != StIdle);
   assign idle          = (state_q == StIdle) && rxs;
   assign overrun_error = ovr_q;
   assign frame_error   = ferr_p_q;
   assign parity_error  = perr_p_q;
   assign break_det     = brk_q;
   assign rx_timeout    = to_p_q;
endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: table of frame formats plus hand-written
// sequences for timeout, overrun, break, glitch, reset and enable corners.
module tb_uart_rx_ovs;
   localparam int TickClk  = 4;
   localparam int BitTicks = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       rxd = 1'b1;
   logic [1:0] div = 2'd0;
   logic       baud_clk;
   logic [2:0] data_bits = 3'd0;
   logic       stop_bits = 1'b0;
   logic       parity_en = 1'b0;
   logic       parity_type = 1'b0;
   logic       busy, idle, overrun_error, frame_error, parity_error, break_det, rx_timeout;

   taxi_axis_if #(.DATA_W(9), .USER_W(2)) axis_if ();

   uart_rx_ovs #(.OVERSAMPLE(16), .MAX_DATA_W(9), .TIMEOUT_BITS(10)) dut (
      .clk(clk), .rst(rst), .en(en), .baud_clk(baud_clk), .rxd(rxd), .m_axis(axis_if),
      .data_bits(data_bits), .stop_bits(stop_bits), .parity_en(parity_en),
      .parity_type(parity_type), .busy(busy), .idle(idle), .overrun_error(overrun_error),
      .frame_error(frame_error), .parity_error(parity_error), .break_det(break_det),
      .rx_timeout(rx_timeout)
   );

   always #5 clk = ~clk;

   // Free-running baud strobe: one clk in every TickClk.
   always @(posedge clk) div <= div + 2'd1;
   assign baud_clk = (div == 2'd3);

   int checks = 0, failures = 0;
   int cyc = 0, xfer_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, brk_cnt = 0, to_cnt = 0;
   int push_cyc = 0, to_cyc = 0;
   logic [8:0] last_data = '0;
   logic [1:0] last_user = '0;
   logic       tv_prev = 1'b0;

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (axis_if.tvalid && axis_if.tready) begin
         xfer_cnt  = xfer_cnt + 1;
         last_data = axis_if.tdata;
         last_user = axis_if.tuser;
      end
      if (axis_if.tvalid && !tv_prev) push_cyc = cyc;
      tv_prev = axis_if.tvalid;
      if (frame_error)   ferr_cnt = ferr_cnt + 1;
      if (parity_error)  perr_cnt = perr_cnt + 1;
      if (overrun_error) ovr_cnt = ovr_cnt + 1;
      if (break_det)     brk_cnt = brk_cnt + 1;
      if (rx_timeout) begin
         to_cnt = to_cnt + 1;
         to_cyc = cyc;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic b, input int ticks);
      rxd = b;
      repeat (ticks * TickClk) @(negedge clk);
   endtask

   function automatic int nbits_of(input logic [2:0] db);
      case (db)
         3'd1: return 7;
         3'd2: return 6;
         3'd3: return 5;
         3'd4: return 9;
         default: return 8;
      endcase
   endfunction

   // One frame at the current config, followed by a full idle bit.
   // gbit >= 0 puts a one-tick inverted glitch at mid-bit of that data bit.
   task automatic send_frame(input logic [8:0] word, input logic flip_par, input logic s2v,
                             input int gbit);
      int   n;
      logic par;
      n   = nbits_of(data_bits);
      par = parity_type;
      hold(1'b0, BitTicks);
      for (int i = 0; i < n; i++) begin
         par = par ^ word[i];
         if (i == gbit) begin
            hold(word[i], 8);
            hold(~word[i], 1);
            hold(word[i], 7);
         end else begin
            hold(word[i], BitTicks);
         end
      end
      if (parity_en) hold(par ^ flip_par, BitTicks);
      hold(1'b1, BitTicks);
      if (stop_bits) hold(s2v, BitTicks);
      hold(1'b1, BitTicks);
   endtask

   typedef struct {
      logic [2:0] db;
      logic       sb, pe, pt;
      logic [8:0] word;
      logic       flip, s2v;
      logic [8:0] exp_data;
      logic       exp_err, exp_ferr, exp_perr;
   } vec_t;

   vec_t vecs [11];
   int   x0, f0, p0, o0, b0, t0;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          db    sb    pe    pt    word     flip  s2v   exp_data err   ferr  perr
      vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{3'd0, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{3'd0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{3'd0, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{3'd4, 1'b1, 1'b1, 1'b1, 9'h1C3, 1'b1, 1'b1, 9'h1C3, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{3'd4, 1'b1, 1'b1, 1'b1, 9'h1C3, 1'b0, 1'b0, 9'h1C3, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{3'd1, 1'b0, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{3'd3, 1'b1, 1'b0, 1'b0, 9'h013, 1'b0, 1'b1, 9'h013, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{3'd2, 1'b0, 1'b1, 1'b0, 9'h02A, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{3'd5, 1'b0, 1'b0, 1'b0, 9'h03C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{3'd1, 1'b0, 1'b1, 1'b1, 9'h040, 1'b1, 1'b1, 9'h040, 1'b1, 1'b0, 1'b1};

      axis_if.tready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_busy", busy, 0);
      check("reset_idle", idle, 1);
      check("reset_tvalid", axis_if.tvalid, 0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("reset_tdata", axis_if.tdata, 0);
      check("reset_tuser", axis_if.tuser, 0);

      for (int i = 0; i < 11; i++) begin
         data_bits   = vecs[i].db;
         stop_bits   = vecs[i].sb;
         parity_en   = vecs[i].pe;
         parity_type = vecs[i].pt;
         hold(1'b1, 4);
         x0 = xfer_cnt; f0 = ferr_cnt; p0 = perr_cnt;
         send_frame(vecs[i].word, vecs[i].flip, vecs[i].s2v, -1);
         #1;
         check($sformatf("v%0d_words", i), xfer_cnt - x0, 1);
         check($sformatf("v%0d_tdata", i), last_data, vecs[i].exp_data);
         check($sformatf("v%0d_tuser", i), last_user, {1'b0, vecs[i].exp_err});
         check($sformatf("v%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
         check($sformatf("v%0d_perr", i), perr_cnt - p0, vecs[i].exp_perr);
      end

      // Idle timeout: 10 bit-times of 16 ticks after the push.
      data_bits = 3'd0; stop_bits = 1'b0; parity_en = 1'b0; parity_type = 1'b0;
      hold(1'b1, 4);
      t0 = to_cnt;
      send_frame(9'h0A5, 1'b0, 1'b1, -1);
      hold(1'b1, 200);
      #1;
      check("timeout_pulses", to_cnt - t0, 1);
      check("timeout_delay_clks", to_cyc - push_cyc, 160 * TickClk);

      // Overrun: 7E1 with the sink stalled.
      data_bits = 3'd1; parity_en = 1'b1;
      axis_if.tready = 1'b0;
      hold(1'b1, 4);
      o0 = ovr_cnt; x0 = xfer_cnt;
      send_frame(9'h055, 1'b0, 1'b1, -1);
      #1;
      check("ovr_first_valid", axis_if.tvalid, 1);
      check("ovr_first_data", axis_if.tdata, 9'h055);
      send_frame(9'h02A, 1'b0, 1'b1, -1);
      #1;
      check("ovr_pulse", ovr_cnt - o0, 1);
      check("ovr_held_data", axis_if.tdata, 9'h055);
      @(posedge clk);
      #1;
      axis_if.tready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("ovr_release_xfers", xfer_cnt - x0, 1);
      check("ovr_release_data", last_data, 9'h055);
      check("ovr_release_valid", axis_if.tvalid, 0);

      // Break: line low for 20 bit-times.
      data_bits = 3'd0; parity_en = 1'b0;
      hold(1'b1, 4);
      b0 = brk_cnt; x0 = xfer_cnt; f0 = ferr_cnt;
      hold(1'b0, 20 * BitTicks);
      #1;
      check("brk_pulse", brk_cnt - b0, 1);
      check("brk_no_word", xfer_cnt - x0, 0);
      check("brk_busy", busy, 1);
      check("brk_not_idle", idle, 0);
      hold(1'b1, 4);
      #1;
      check("brk_idle_after", idle, 1);
      check("brk_no_ferr", ferr_cnt - f0, 0);

      // Short low glitch is a false start.
      x0 = xfer_cnt;
      hold(1'b0, 4);
      #1;
      check("glitch_busy", busy, 1);
      hold(1'b1, 20);
      #1;
      check("glitch_no_word", xfer_cnt - x0, 0);
      check("glitch_idle", idle, 1);

`ifdef UART_RX_MAJORITY_EN
      // One-tick high glitch at the middle of a zero data bit is voted out.
      x0 = xfer_cnt;
      send_frame(9'h05A, 1'b0, 1'b1, 0);
      #1;
      check("maj_words", xfer_cnt - x0, 1);
      check("maj_data", last_data, 9'h05A);
`endif

      // Reset in the middle of the data bits of 0x3C.
      x0 = xfer_cnt;
      hold(1'b0, BitTicks);
      hold(1'b0, 2 * BitTicks);
      hold(1'b1, 8);
      rst = 1'b1;
      rxd = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_tvalid", axis_if.tvalid, 0);
      hold(1'b1, 4);
      rst = 1'b0;
      hold(1'b1, 4);
      send_frame(9'h03C, 1'b0, 1'b1, -1);
      #1;
      check("rst_next_words", xfer_cnt - x0, 1);
      check("rst_next_data", last_data, 9'h03C);

      // Enable dropped mid-frame.
      x0 = xfer_cnt;
      hold(1'b0, BitTicks);
      hold(1'b0, 8);
      en  = 1'b0;
      rxd = 1'b1;
      #1;
      check("en_busy_same_clk", busy, 1);
      @(negedge clk);
      #1;
      check("en_busy_next_clk", busy, 0);
      hold(1'b1, 8);
      en = 1'b1;
      hold(1'b1, 4);
      send_frame(9'h03C, 1'b0, 1'b1, -1);
      #1;
      check("en_next_words", xfer_cnt - x0, 1);
      check("en_next_data", last_data, 9'h03C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
